nmk111_bus_arb: RTL and testbench

Bus arbiter and strobe sequencer for the NMK-111 bidirectional latch/transceiver. It shares the A/B bus between a CPU requester (read or write) and a DMA requester (read only), and drives the transceiver's chip select and direction. It also produces the first-stage latch strobe on CPU writes and the second-stage transfer strobe on vertical blank. It sits between the CPU/DMA address decode and the NMK-111 control pins.

---
 rtl/nmk111_bus_arb.sv | 161 ++++++++++++++++
 tb/tb_nmk111_bus_arb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nmk111_bus_arb.sv
// nmk111_bus_arb: shares the NMK-111 A/B bus between CPU and DMA and sequences LATCH/XFER strobes.
// Define NMK111_ARB_TURNAROUND_EN to insert one nCS-high TURN cycle whenever DIR must change.
module nmk111_bus_arb #(
  parameter int HOLD_CYC = 2
) (
  input  logic CLK1,
  input  logic RST,
  input  logic i_cpu_req,
  input  logic i_cpu_wr,
  input  logic i_dma_req,
  input  logic i_vblank,
  output logic o_cpu_ack,
  output logic o_dma_ack,
  output logic o_ncs,
  output logic o_dir,
  output logic o_latch,
  output logic o_xfer,
  output logic o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TURN  = 2'd1,
    S_GRANT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [3:0] HOLD    = 4'(HOLD_CYC);
  localparam logic       OWN_CPU = 1'b0;
  localparam logic       OWN_DMA = 1'b1;

  state_t     r_state, w_state_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic       r_owner, w_owner_n;
  logic       r_wr, w_wr_n;
  logic       r_dir, w_dir_n;
  logic       r_ptr, w_ptr_n;
  logic       w_win;
  logic       r_vb_s1, r_vb_s2, r_vb_d;
  logic       r_pending, w_pending_n, w_rise;
  logic       w_ncs_n, w_cpu_ack_n, w_dma_ack_n, w_latch_n, w_xfer_n, w_busy_n, w_wgrant_n;
  logic       r_ncs, r_cpu_ack, r_dma_ack, r_latch, r_xfer, r_busy;

  // Next-state: arbitration in IDLE, hold countdown in GRANT.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_owner_n = r_owner;
    w_wr_n    = r_wr;
    w_dir_n   = r_dir;
    w_ptr_n   = r_ptr;
    w_win     = OWN_CPU;
    case (r_state)
      S_IDLE: begin
        if (i_cpu_req || i_dma_req) begin
          if (i_cpu_req && i_dma_req) begin
            w_win = r_ptr;
          end else begin
            w_win = i_dma_req;
          end
          w_owner_n = w_win;
          w_wr_n    = (w_win == OWN_CPU) & i_cpu_wr;
          w_dir_n   = (w_win == OWN_DMA) | ~i_cpu_wr;
          w_cnt_n   = HOLD;
          w_state_n = S_GRANT;
`ifdef NMK111_ARB_TURNAROUND_EN
          if (w_dir_n != r_dir) begin
            w_state_n = S_TURN;
            w_cnt_n   = r_cnt;
          end else begin
            w_state_n = S_GRANT;
          end
`endif
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_TURN: begin
        w_state_n = S_GRANT;
        w_cnt_n   = HOLD;
      end
      S_GRANT: begin
        if (r_cnt <= 4'd1) begin
          w_state_n = S_GAP;
          w_cnt_n   = 4'd0;
          w_ptr_n   = ~r_owner;
        end else begin
          w_cnt_n   = r_cnt - 4'd1;
        end
      end
      S_GAP: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = 4'd0;
      end
    endcase
  end

  // Output values for the coming cycle; XFER is held off while REG_1 is being written.
  always_comb begin
    w_busy_n    = (w_state_n != S_IDLE);
    w_ncs_n     = (w_state_n != S_GRANT);
    w_cpu_ack_n = (w_state_n == S_GRANT) && (w_cnt_n == 4'd1) && (w_owner_n == OWN_CPU);
    w_dma_ack_n = (w_state_n == S_GRANT) && (w_cnt_n == 4'd1) && (w_owner_n == OWN_DMA);
    w_wgrant_n  = (w_state_n == S_GRANT) && w_wr_n;
    w_latch_n   = (w_state_n == S_GAP) && w_wr_n;
    w_rise      = r_vb_s2 & ~r_vb_d;
    w_xfer_n    = (r_pending | w_rise) & ~w_latch_n & ~w_wgrant_n;
    w_pending_n = (r_pending | w_rise) & ~w_xfer_n;
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_owner   <= OWN_CPU;
      r_wr      <= 1'b0;
      r_dir     <= 1'b0;
      r_ptr     <= OWN_CPU;
      r_vb_s1   <= 1'b0;
      r_vb_s2   <= 1'b0;
      r_vb_d    <= 1'b0;
      r_pending <= 1'b0;
      r_ncs     <= 1'b1;
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      r_latch   <= 1'b0;
      r_xfer    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_owner   <= w_owner_n;
      r_wr      <= w_wr_n;
      r_dir     <= w_dir_n;
      r_ptr     <= w_ptr_n;
      r_vb_s1   <= i_vblank;
      r_vb_s2   <= r_vb_s1;
      r_vb_d    <= r_vb_s2;
      r_pending <= w_pending_n;
      r_ncs     <= w_ncs_n;
      r_cpu_ack <= w_cpu_ack_n;
      r_dma_ack <= w_dma_ack_n;
      r_latch   <= w_latch_n;
      r_xfer    <= w_xfer_n;
      r_busy    <= w_busy_n;
    end
  end

  assign o_cpu_ack = r_cpu_ack;
  assign o_dma_ack = r_dma_ack;
  assign o_ncs     = r_ncs;
  assign o_dir     = r_dir;
  assign o_latch   = r_latch;
  assign o_xfer    = r_xfer;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_nmk111_bus_arb.sv
// tb_nmk111_bus_arb: directed scenarios plus random traffic, checked every cycle against a
// slot-schedule model of grants and a rule-level model of the VBLANK transfer strobe.
module tb_nmk111_bus_arb;
  localparam int HOLD = 2;
`ifdef NMK111_ARB_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  logic CLK1 = 1'b0;
  logic RST = 1'b1;
  logic cpu_req = 1'b0, cpu_wr = 1'b0, dma_req = 1'b0, vblank = 1'b0;
  logic cpu_ack, dma_ack, ncs, dir, latch, xfer, busy;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en = 1'b0;

  always #5 CLK1 = ~CLK1;

  nmk111_bus_arb #(.HOLD_CYC(HOLD)) dut (
    .CLK1(CLK1), .RST(RST),
    .i_cpu_req(cpu_req), .i_cpu_wr(cpu_wr), .i_dma_req(dma_req), .i_vblank(vblank),
    .o_cpu_ack(cpu_ack), .o_dma_ack(dma_ack), .o_ncs(ncs), .o_dir(dir),
    .o_latch(latch), .o_xfer(xfer), .o_busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: every bus cycle is a slot; a grant is scheduled as a list of slots.
  typedef struct packed {
    bit ncs, dir, cack, dack, latch, wgrant, busy, ptr_upd, ptr_val;
  } slot_t;

  slot_t    m_cur;
  slot_t    m_q[$];
  bit       m_ptr, m_pend, m_xfer;
  bit [2:0] m_vh;

  function automatic slot_t mk(bit n, bit d, bit b);
    slot_t s;
    s = '0;
    s.ncs = n; s.dir = d; s.busy = b;
    return s;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur  = mk(1'b1, 1'b0, 1'b0);
    m_ptr  = 1'b0;
    m_pend = 1'b0;
    m_xfer = 1'b0;
    m_vh   = 3'b000;
  endtask

  task automatic model_step();
    bit rise, win, nd, wr, p;
    slot_t s;
    rise = m_vh[1] & ~m_vh[2];
    m_vh = {m_vh[1:0], vblank};
    if (!m_cur.busy) begin
      if (cpu_req || dma_req) begin
        win = (cpu_req && dma_req) ? m_ptr : dma_req;
        nd  = win | ~cpu_wr;
        wr  = !win && cpu_wr;
        if (TURN_EN && nd != m_cur.dir) m_q.push_back(mk(1'b1, nd, 1'b1));
        for (int i = 1; i <= HOLD; i++) begin
          s = mk(1'b0, nd, 1'b1);
          s.wgrant = wr;
          s.cack = (i == HOLD) && !win;
          s.dack = (i == HOLD) && win;
          m_q.push_back(s);
        end
        s = mk(1'b1, nd, 1'b1);
        s.latch = wr; s.ptr_upd = 1'b1; s.ptr_val = !win;
        m_q.push_back(s);
        m_cur = m_q.pop_front();
      end
    end else if (m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      if (m_cur.ptr_upd) m_ptr = m_cur.ptr_val;
    end else begin
      m_cur = mk(1'b1, m_cur.dir, 1'b0);
    end
    p      = m_pend | rise;
    m_xfer = p && !m_cur.latch && !m_cur.wgrant;
    m_pend = p && !m_xfer;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK1 or posedge RST);
      if (RST) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge CLK1);
      if (chk_en) begin
        chk("ncs", ncs, m_cur.ncs);
        chk("dir", dir, m_cur.dir);
        chk("busy", busy, m_cur.busy);
        chk("cpu_ack", cpu_ack, m_cur.cack);
        chk("dma_ack", dma_ack, m_cur.dack);
        chk("latch", latch, m_cur.latch);
        chk("xfer", xfer, m_xfer);
      end
    end
  end

  initial begin
    int n_ack, falls, turn_falls, lat_at, xf_at, xf_cnt, overlap, first;
    bit p_ncs, p_busy;
    repeat (3) @(negedge CLK1);
    chk_en = 1'b1;
    RST = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge CLK1);
      chk("idle_ncs", ncs, 1'b1); chk("idle_dir", dir, 1'b0); chk("idle_busy", busy, 1'b0);
      chk("idle_latch", latch, 1'b0); chk("idle_xfer", xfer, 1'b0);
    end

    // single CPU write from DIR=0
    cpu_wr = 1'b1; cpu_req = 1'b1;
    @(negedge CLK1);
    chk("t2_ncs1", ncs, 1'b0); chk("t2_dir1", dir, 1'b0); chk("t2_ack1", cpu_ack, 1'b0);
    @(negedge CLK1);
    chk("t2_ncs2", ncs, 1'b0); chk("t2_ack2", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    @(negedge CLK1);
    chk("t2_ncs3", ncs, 1'b1); chk("t2_latch", latch, 1'b1); chk("t2_ack3", cpu_ack, 1'b0);
    @(negedge CLK1);
    chk("t2_latch_off", latch, 1'b0); chk("t2_busy_off", busy, 1'b0);

    // both requesters held high from reset
    RST = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b1; dma_req = 1'b1;
    @(negedge CLK1);
    RST = 1'b0;
    n_ack = 0; falls = 0; turn_falls = 0; p_ncs = 1'b1; p_busy = 1'b0;
    repeat (60) begin
      @(negedge CLK1);
      if (cpu_ack || dma_ack) begin
        chk("t3_owner", dma_ack, 32'(n_ack % 2));
        n_ack++;
      end
      if (!ncs && p_ncs) begin
        falls++;
        if (p_busy) turn_falls++;
      end
      p_ncs = ncs; p_busy = busy;
    end
    chk("t3_grants", 32'(n_ack >= 4), 32'd1);
    chk("t3_turns", 32'(turn_falls), TURN_EN ? 32'(falls - 1) : 32'd0);
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (6) @(negedge CLK1);

    // VBLANK edge landing on the LATCH cycle
    cpu_wr = 1'b1; cpu_req = 1'b1; vblank = 1'b1;
    lat_at = -1; xf_at = -1; xf_cnt = 0; overlap = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge CLK1);
      if (cpu_ack) cpu_req = 1'b0;
      if (latch) lat_at = j;
      if (xfer) begin
        xf_cnt++; xf_at = j;
        if (latch) overlap++;
      end
    end
    chk("t4_xfer_count", 32'(xf_cnt), 32'd1);
    chk("t4_overlap", 32'(overlap), 32'd0);
    chk("t4_xfer_after_latch", 32'(lat_at >= 0 && xf_at == lat_at + 1), 32'd1);
    vblank = 1'b0;
    repeat (6) @(negedge CLK1);

    // two VBLANK edges two cycles apart around a CPU write grant
    xf_cnt = 0;
    vblank = 1'b1;
    @(negedge CLK1);
    if (xfer) xf_cnt++;
    vblank = 1'b0;
    @(negedge CLK1);
    if (xfer) xf_cnt++;
    vblank = 1'b1; cpu_wr = 1'b1; cpu_req = 1'b1;
    repeat (12) begin
      @(negedge CLK1);
      if (cpu_ack) cpu_req = 1'b0;
      if (xfer) xf_cnt++;
    end
    chk("t5_xfer_count", 32'(xf_cnt), 32'd1);
    vblank = 1'b0;
    repeat (6) @(negedge CLK1);

    // reset on the first GRANT cycle of a CPU write
    cpu_wr = 1'b1; cpu_req = 1'b1;
    @(negedge CLK1);
    chk("t6_pre_ncs", ncs, 1'b0);
    RST = 1'b1; dma_req = 1'b1;
    #1;
    chk("t6_rst_ncs", ncs, 1'b1); chk("t6_rst_ack", cpu_ack, 1'b0);
    chk("t6_rst_latch", latch, 1'b0); chk("t6_rst_busy", busy, 1'b0);
    @(negedge CLK1);
    RST = 1'b0;
    first = -1;
    for (int j = 0; j < 10; j++) begin
      @(negedge CLK1);
      if (first < 0 && (cpu_ack || dma_ack)) first = int'(dma_ack);
      if (cpu_ack) cpu_req = 1'b0;
    end
    chk("t6_first_owner", 32'(first), 32'd0);
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (6) @(negedge CLK1);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLK1);
      if (cpu_ack) cpu_req = 1'b0;
      else if (cpu_req && busy && $urandom_range(0, 39) == 0) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1'b1; cpu_wr = 1'($urandom_range(0, 1));
      end
      if (dma_ack) dma_req = 1'b0;
      else if (!dma_req && $urandom_range(0, 3) == 0) dma_req = 1'b1;
      if ($urandom_range(0, 15) == 0) vblank = ~vblank;
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 599) == 0) RST = 1'b1;
    end
    RST = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    repeat (8) @(negedge CLK1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
